// File: rtl/cpu_host_driver_pkg.sv
// Shared encodings for the CPU host command driver.
// Command kinds, FSM states and the default EXEC settle time.
package cpu_host_driver_pkg;

    localparam int unsigned EXEC_WAIT_DEF = 3;

    typedef enum logic [1:0] {
        KIND_LOAD = 2'b00,
        KIND_EXEC = 2'b01,
        KIND_READ = 2'b10,
        KIND_ILL  = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESULT = 2'b11
    } state_t;

endpackage

// File: rtl/cpu_host_driver.sv
// Host-side driver: turns LOAD/EXEC/READ commands into CPU strobes
// and hands results to a valid/ready consumer.
module cpu_host_driver
    import cpu_host_driver_pkg::*;
#(
    parameter int unsigned EXEC_WAIT = EXEC_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [2:0]  cmd_reg,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_cin,
    output logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_opcode,
    output logic        cpu_cin,
    output logic        cpu_load,
    output logic        cpu_ce,
    input  logic [7:0]  cpu_data_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        cmd_err,
    output logic [15:0] cmd_count
);

    localparam int unsigned CW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            is_exec;

    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            is_exec     <= 1'b0;
            cpu_data_in <= 8'h00;
            cpu_opcode  <= 8'h00;
            cpu_cin     <= 1'b0;
            cpu_load    <= 1'b0;
            cpu_ce      <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 8'h00;
            cmd_err     <= 1'b0;
            cmd_count   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_count <= cmd_count + 16'd1;
                        is_exec   <= 1'b0;
                        case (kind_t'(cmd_kind))
                            KIND_LOAD: begin
                                state       <= ST_DRIVE;
                                cpu_ce      <= 1'b1;
                                cpu_load    <= 1'b1;
                                cpu_data_in <= cmd_data;
                                cpu_opcode  <= {1'b0, cmd_reg, 4'h0};
                            end
                            KIND_EXEC: begin
                                state      <= ST_DRIVE;
                                cpu_ce     <= 1'b1;
                                cpu_load   <= 1'b0;
                                cpu_opcode <= {1'b0, cmd_reg, cmd_op};
                                cpu_cin    <= cmd_cin;
                                is_exec    <= 1'b1;
                            end
                            KIND_READ: begin
                                state     <= ST_RESULT;
                                res_valid <= 1'b1;
                                res_data  <= cpu_data_out;
                            end
                            KIND_ILL: begin
                                cmd_err <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_DRIVE: begin
                    cpu_ce   <= 1'b0;
                    cpu_load <= 1'b0;
                    if (is_exec) begin
                        state    <= ST_WAIT;
                        wait_cnt <= CW'(EXEC_WAIT - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Capture on the final settle edge, not before.
                    if (wait_cnt == '0) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                        res_data  <= cpu_data_out;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_host_driver.sv
// Self-checking bench for cpu_host_driver: directed scenarios plus
// random commands against a transaction-level expectation model.
module tb_cpu_host_driver;
    import cpu_host_driver_pkg::*;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [2:0]  cmd_reg;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_cin;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_opcode;
    logic        cpu_cin;
    logic        cpu_load;
    logic        cpu_ce;
    logic [7:0]  cpu_data_out;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        cmd_err;
    logic [15:0] cmd_count;

    always #5 clk = ~clk;

    cpu_host_driver #(.EXEC_WAIT(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kind     (cmd_kind),
        .cmd_reg      (cmd_reg),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_cin      (cmd_cin),
        .cpu_data_in  (cpu_data_in),
        .cpu_opcode   (cpu_opcode),
        .cpu_cin      (cpu_cin),
        .cpu_load     (cpu_load),
        .cpu_ce       (cpu_ce),
        .cpu_data_out (cpu_data_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .cmd_err      (cmd_err),
        .cmd_count    (cmd_count)
    );

    int checks = 0;
    int errors = 0;

    // Expected architectural state: command count, sticky error and
    // the last values driven onto the CPU bus.
    logic [15:0] m_count;
    logic        m_err;
    logic [7:0]  m_din;
    logic [7:0]  m_op;
    logic        m_cin;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ce,
                             input logic ld, input logic rv,
                             input logic rdy);
        chk({tag, ".ce"},    16'(cpu_ce),      16'(ce));
        chk({tag, ".load"},  16'(cpu_load),    16'(ld));
        chk({tag, ".rvld"},  16'(res_valid),   16'(rv));
        chk({tag, ".ready"}, 16'(cmd_ready),   16'(rdy));
        chk({tag, ".din"},   16'(cpu_data_in), 16'(m_din));
        chk({tag, ".op"},    16'(cpu_opcode),  16'(m_op));
        chk({tag, ".cin"},   16'(cpu_cin),     16'(m_cin));
        chk({tag, ".err"},   16'(cmd_err),     16'(m_err));
        chk({tag, ".count"}, cmd_count,        m_count);
    endtask

    task automatic model_clear();
        m_count = '0;
        m_err   = 1'b0;
        m_din   = '0;
        m_op    = '0;
        m_cin   = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        model_clear();
        @(negedge clk);
        chk_state("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst.rdata", 16'(res_data), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.first_ready", 16'(cmd_ready), 16'h1);
    endtask

    // Issue one command from IDLE and follow it back to IDLE.
    task automatic do_cmd(input logic [1:0] k, input logic [2:0] r,
                          input logic [3:0] o, input logic [7:0] d,
                          input logic c, input int hold,
                          input int fixed);
        logic [7:0] exp_res;
        chk("pre.ready", 16'(cmd_ready), 16'h1);
        cmd_valid    = 1'b1;
        cmd_kind     = k;
        cmd_reg      = r;
        cmd_op       = o;
        cmd_data     = d;
        cmd_cin      = c;
        cpu_data_out = 8'($urandom);
        res_ready    = 1'($urandom);
        exp_res      = cpu_data_out;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_kind  = 2'($urandom);
        cmd_reg   = 3'($urandom);
        cmd_op    = 4'($urandom);
        cmd_data  = 8'($urandom);
        cmd_cin   = 1'($urandom);
        m_count   = m_count + 16'd1;
        if (k == KIND_LOAD) begin
            m_din = d;
            m_op  = {1'b0, r, 4'h0};
            chk_state("load.drive", 1'b1, 1'b1, 1'b0, 1'b0);
            res_ready = 1'($urandom);
            @(negedge clk);
            chk_state("load.done", 1'b0, 1'b0, 1'b0, 1'b1);
        end else if (k == KIND_EXEC) begin
            m_op  = {1'b0, r, o};
            m_cin = c;
            chk_state("exec.drive", 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i <= W; i++) begin
                if (fixed >= 0 && i == W) cpu_data_out = 8'(fixed);
                else cpu_data_out = 8'($urandom);
                exp_res   = cpu_data_out;
                res_ready = 1'($urandom);
                @(negedge clk);
                if (i < W) chk_state("exec.wait", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end else if (k == KIND_ILL) begin
            m_err = 1'b1;
            chk_state("ill", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (k == KIND_EXEC || k == KIND_READ) begin
            chk_state("res", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("res.data", 16'(res_data), 16'(exp_res));
            for (int i = 0; i < hold; i++) begin
                res_ready    = 1'b0;
                cpu_data_out = 8'($urandom);
                @(negedge clk);
                chk_state("res.hold", 1'b0, 1'b0, 1'b1, 1'b0);
                chk("res.hold.data", 16'(res_data), 16'(exp_res));
            end
            res_ready = 1'b1;
            @(negedge clk);
            chk_state("res.done", 1'b0, 1'b0, 1'b0, 1'b1);
            res_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_at [4];
        int ce_cnt;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_kind     = '0;
        cmd_reg      = '0;
        cmd_op       = '0;
        cmd_data     = '0;
        cmd_cin      = 1'b0;
        cpu_data_out = '0;
        res_ready    = 1'b0;
        do_reset();

        do_cmd(KIND_LOAD, 3'd3, 4'h0, 8'h5A, 1'b0, 0, -1);
        chk("load.opcode", 16'(cpu_opcode), 16'h0030);
        do_cmd(KIND_EXEC, 3'd2, 4'h4, 8'h00, 1'b1, 0, 8'h7E);
        chk("exec.rdata", 16'(res_data), 16'h007E);
        chk("exec.opcode", 16'(cpu_opcode), 16'h0024);
        do_cmd(KIND_EXEC, 3'd5, 4'hB, 8'h00, 1'b0, 10, -1);
        do_cmd(KIND_READ, 3'd0, 4'h0, 8'h00, 1'b0, 2, -1);

        do_cmd(KIND_ILL, 3'd1, 4'h1, 8'h33, 1'b1, 0, -1);
        do_cmd(KIND_LOAD, 3'd6, 4'h0, 8'hC3, 1'b0, 0, -1);
        chk("ill.sticky", 16'(cmd_err), 16'h1);

        // LOAD then EXEC with cmd_valid held high throughout.
        do_reset();
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_kind  = KIND_LOAD;
        cmd_reg   = 3'd1;
        cmd_data  = 8'h11;
        cmd_cin   = 1'b0;
        ce_cnt    = 0;
        ce_at     = '{default: 0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1 && ce_cnt < 4) begin
                ce_at[ce_cnt] = i;
                ce_cnt++;
            end
            if (i == 0) begin
                cmd_kind = KIND_EXEC;
                cmd_reg  = 3'd2;
                cmd_op   = 4'h5;
            end
            if (i == 2) cmd_valid = 1'b0;
        end
        res_ready = 1'b0;
        chk("b2b.pulses", 16'(ce_cnt), 16'd2);
        chk("b2b.gap", 16'(ce_at[1] - ce_at[0]), 16'd2);
        m_count = 16'd2;
        m_din   = 8'h11;
        m_op    = {1'b0, 3'd2, 4'h5};
        m_cin   = 1'b0;
        chk_state("b2b.end", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the second WAIT cycle aborts the EXEC.
        cmd_valid    = 1'b1;
        cmd_kind     = KIND_EXEC;
        cmd_reg      = 3'd7;
        cmd_op       = 4'h9;
        cmd_cin      = 1'b1;
        cpu_data_out = 8'hA5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        chk_state("rstwait", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rstwait.rdata", 16'(res_data), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwait.first_ready", 16'(cmd_ready), 16'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_state("rstwait.quiet", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        for (int n = 0; n < 60; n++) begin
            do_cmd(2'($urandom), 3'($urandom), 4'($urandom),
                   8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
